// File: rtl/motor_sched_pkg.sv
// Shared definitions for the actuator command scheduler: FSM states,
// grant codes and the request-byte to positioner-target scaling.
package motor_sched_pkg;

   typedef enum logic [2:0] {
      ST_HOME_REQ,
      ST_HOME_WAIT,
      ST_IDLE,
      ST_ISSUE,
      ST_MOVE,
      ST_SETTLE,
      ST_FAULT
   } sched_state_t;

   localparam logic [1:0] GNT_NONE = 2'd0;
   localparam logic [1:0] GNT_SAFE = 2'd1;
   localparam logic [1:0] GNT_LOC  = 2'd2;
   localparam logic [1:0] GNT_REM  = 2'd3;

   localparam int DEF_SCALE_SHIFT = 3;

   // Zero-extend before shifting so the top bits of the byte are kept.
   function automatic logic [10:0] scale_target(input logic [7:0] b, input int sh);
      return 11'(b) << sh;
   endfunction

endpackage

// File: rtl/motor_cmd_sched_req_latch.sv
// Pulse-to-pending latch: a request pulse arms it and captures the payload,
// consume disarms it, clear discards both pending and any same-cycle pulse.
module req_latch #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         req,
   input  logic [W-1:0] pos_in,
   input  logic         consume,
   input  logic         clear,
   output logic         pending,
   output logic [W-1:0] pos
);

   // A pulse coinciding with consume re-arms with the new payload.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pending <= 1'b0;
         pos     <= '0;
      end else if (clear) begin
         pending <= 1'b0;
      end else if (req) begin
         pending <= 1'b1;
         pos     <= pos_in;
      end else if (consume) begin
         pending <= 1'b0;
      end
   end

endmodule

// File: rtl/motor_cmd_sched.sv
// Actuator command scheduler: homes the positioner, arbitrates safe > loc > rem,
// issues one move at a time, and enforces settle dead time and a stall watchdog.
module motor_cmd_sched
   import motor_sched_pkg::*;
#(
   parameter int TIMEOUT_TICKS = 2600,
   parameter int SETTLE_TICKS  = 2,
   parameter int SCALE_SHIFT   = DEF_SCALE_SHIFT
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        tick,
   input  logic        safe_req,
   input  logic [7:0]  safe_pos,
   input  logic        loc_req,
   input  logic [7:0]  loc_pos,
   input  logic        rem_req,
   input  logic [7:0]  rem_pos,
   input  logic        pos_ready,
   output logic        pos_home,
   output logic        pos_load,
   output logic [10:0] pos_target,
   output logic [1:0]  grant,
   output logic        busy,
   output logic        done,
   output logic        fault
);

   localparam int CNT_W = $clog2(TIMEOUT_TICKS + 1);
   localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT_TICKS);
   localparam logic [CNT_W-1:0] ST_CNT = CNT_W'(SETTLE_TICKS);

   sched_state_t     state, state_d;
   logic [CNT_W-1:0] wd_cnt, wd_cnt_d, wd_inc;
   logic [CNT_W-1:0] st_cnt, st_cnt_d, st_inc;
   logic             guard, ready_ok, safe_elig;
   logic             go_issue, home_d, done_d;
   logic [1:0]       sel_gnt;
   logic [10:0]      sel_target, safe_target;
   logic             loc_pend, rem_pend, loc_consume, rem_consume;
   logic [7:0]       loc_byte, rem_byte;

   req_latch #(.W(8)) u_loc_latch (
      .clk(clk), .rst_n(rst_n), .req(loc_req), .pos_in(loc_pos),
      .consume(loc_consume), .clear(safe_req), .pending(loc_pend), .pos(loc_byte)
   );

   req_latch #(.W(8)) u_rem_latch (
      .clk(clk), .rst_n(rst_n), .req(rem_req), .pos_in(rem_pos),
      .consume(rem_consume), .clear(safe_req), .pending(rem_pend), .pos(rem_byte)
   );

   assign safe_target = scale_target(safe_pos, SCALE_SHIFT);
   assign safe_elig   = safe_req && (safe_target != pos_target);
   // The positioner may still show ready during the pulse and the cycle after it.
   assign ready_ok    = pos_ready && !pos_home && !pos_load && !guard;
   assign loc_consume = go_issue && (sel_gnt == GNT_LOC);
   assign rem_consume = go_issue && (sel_gnt == GNT_REM);
   assign wd_inc      = wd_cnt + 1'b1;
   assign st_inc      = st_cnt + 1'b1;

   always_comb begin
      state_d    = state;
      wd_cnt_d   = wd_cnt;
      st_cnt_d   = st_cnt;
      go_issue   = 1'b0;
      home_d     = 1'b0;
      done_d     = 1'b0;
      sel_gnt    = GNT_NONE;
      sel_target = pos_target;
      case (state)
         ST_HOME_REQ: begin
            home_d   = 1'b1;
            wd_cnt_d = '0;
            state_d  = ST_HOME_WAIT;
         end
         ST_HOME_WAIT: begin
            if (ready_ok) begin
               state_d = ST_IDLE;
            end else if (tick) begin
               wd_cnt_d = wd_inc;
               if (wd_inc == TO_CNT) state_d = ST_FAULT;
            end
         end
         ST_IDLE: begin
            if (safe_elig) begin
               go_issue   = 1'b1;
               sel_gnt    = GNT_SAFE;
               sel_target = safe_target;
            end else if (!safe_req && loc_pend) begin
               go_issue   = 1'b1;
               sel_gnt    = GNT_LOC;
               sel_target = scale_target(loc_byte, SCALE_SHIFT);
            end else if (!safe_req && rem_pend) begin
               go_issue   = 1'b1;
               sel_gnt    = GNT_REM;
               sel_target = scale_target(rem_byte, SCALE_SHIFT);
            end
         end
         ST_ISSUE: begin
            wd_cnt_d = '0;
            state_d  = ST_MOVE;
         end
         ST_MOVE: begin
            if (grant != GNT_SAFE && safe_elig) begin
               go_issue   = 1'b1;
               sel_gnt    = GNT_SAFE;
               sel_target = safe_target;
            end else if (ready_ok) begin
               done_d   = 1'b1;
               st_cnt_d = '0;
               state_d  = ST_SETTLE;
            end else if (tick) begin
               wd_cnt_d = wd_inc;
               if (wd_inc == TO_CNT) state_d = ST_FAULT;
            end
         end
         ST_SETTLE: begin
            if (grant != GNT_SAFE && safe_elig) begin
               go_issue   = 1'b1;
               sel_gnt    = GNT_SAFE;
               sel_target = safe_target;
            end else if (tick) begin
               st_cnt_d = st_inc;
               if (st_inc == ST_CNT) state_d = ST_IDLE;
            end
         end
         ST_FAULT: state_d = ST_FAULT;
         default:  state_d = ST_HOME_REQ;
      endcase
      if (go_issue) state_d = ST_ISSUE;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= ST_HOME_REQ;
         wd_cnt     <= '0;
         st_cnt     <= '0;
         guard      <= 1'b0;
         pos_home   <= 1'b0;
         pos_load   <= 1'b0;
         pos_target <= '0;
         grant      <= GNT_NONE;
         busy       <= 1'b0;
         done       <= 1'b0;
         fault      <= 1'b0;
      end else begin
         state    <= state_d;
         wd_cnt   <= wd_cnt_d;
         st_cnt   <= st_cnt_d;
         guard    <= pos_home | pos_load;
         pos_home <= home_d;
         pos_load <= go_issue;
         done     <= done_d;
         busy     <= (state_d != ST_IDLE) && (state_d != ST_FAULT);
         fault    <= (state_d == ST_FAULT);
         if (go_issue) begin
            pos_target <= sel_target;
            grant      <= sel_gnt;
         end else if (state_d == ST_IDLE || state_d == ST_FAULT) begin
            grant <= GNT_NONE;
         end
      end
   end

endmodule

// File: tb/tb_motor_cmd_sched.sv
// Directed bench for motor_cmd_sched: homing, remote move, contention,
// safety preemption/lockout, watchdog fault and reset recovery.
module tb_motor_cmd_sched;

   logic        clk;
   logic        rst_n;
   logic        tick;
   logic        safe_req;
   logic [7:0]  safe_pos;
   logic        loc_req;
   logic [7:0]  loc_pos;
   logic        rem_req;
   logic [7:0]  rem_pos;
   logic        pos_ready;
   logic        pos_home;
   logic        pos_load;
   logic [10:0] pos_target;
   logic [1:0]  grant;
   logic        busy;
   logic        done;
   logic        fault;

   int vectors     = 0;
   int miscompares = 0;
   int n_load;
   int n_home;

   motor_cmd_sched #(
      .TIMEOUT_TICKS(16),
      .SETTLE_TICKS(2),
      .SCALE_SHIFT(3)
   ) dut (
      .clk(clk), .rst_n(rst_n), .tick(tick),
      .safe_req(safe_req), .safe_pos(safe_pos),
      .loc_req(loc_req), .loc_pos(loc_pos),
      .rem_req(rem_req), .rem_pos(rem_pos),
      .pos_ready(pos_ready),
      .pos_home(pos_home), .pos_load(pos_load), .pos_target(pos_target),
      .grant(grant), .busy(busy), .done(done), .fault(fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL global_timeout: observed no finish, expected finish before 200000");
      $fatal(1, "bench timeout");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick_step();
      tick = 1'b1;
      step();
      tick = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      while (busy && n < 20) begin
         step();
         n++;
      end
      chk(tag, 32'(busy), 0);
   endtask

   task automatic count_loads(input int cycles);
      n_load = 0;
      n_home = 0;
      for (int i = 0; i < cycles; i++) begin
         step();
         if (pos_load) n_load++;
         if (pos_home) n_home++;
      end
   endtask

   initial begin
      rst_n = 1'b0; tick = 1'b0; safe_req = 1'b0; safe_pos = 8'h00;
      loc_req = 1'b0; loc_pos = 8'h00; rem_req = 1'b0; rem_pos = 8'h00;
      pos_ready = 1'b0;
      step(); step(); step();
      chk("rst_home", 32'(pos_home), 0);
      chk("rst_load", 32'(pos_load), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_grant", 32'(grant), 0);
      chk("rst_target", 32'(pos_target), 0);
      chk("rst_fault", 32'(fault), 0);
      chk("rst_done", 32'(done), 0);

      // Homing with ready low for 5 cycles
      rst_n = 1'b1;
      step();
      chk("home_pulse", 32'(pos_home), 1);
      chk("home_busy", 32'(busy), 1);
      n_home = 1;
      for (int i = 0; i < 4; i++) begin
         step();
         if (pos_home) n_home++;
      end
      chk("home_wait_busy", 32'(busy), 1);
      pos_ready = 1'b1;
      step();
      chk("home_single_pulse", 32'(n_home), 1);
      chk("home_idle_busy", 32'(busy), 0);
      chk("home_idle_grant", 32'(grant), 0);

      // Remote move 0x64 -> 800, load at n+2
      rem_req = 1'b1; rem_pos = 8'h64;
      step();
      rem_req = 1'b0;
      chk("rem_load_n1", 32'(pos_load), 0);
      step();
      chk("rem_load_n2", 32'(pos_load), 1);
      chk("rem_target", 32'(pos_target), 800);
      chk("rem_grant", 32'(grant), 3);
      pos_ready = 1'b0;
      step();
      chk("rem_load_one_cycle", 32'(pos_load), 0);
      step();
      pos_ready = 1'b1;
      step();
      chk("rem_done", 32'(done), 1);
      chk("rem_done_grant", 32'(grant), 3);
      step();
      chk("rem_done_once", 32'(done), 0);
      tick_step();
      chk("rem_settle_1tick_busy", 32'(busy), 1);
      chk("rem_settle_grant_hold", 32'(grant), 3);
      tick_step();
      chk("rem_settle_idle_busy", 32'(busy), 0);
      chk("rem_settle_idle_grant", 32'(grant), 0);

      // Contention, ready held high to exercise the post-load ignore window
      loc_req = 1'b1; loc_pos = 8'd10; rem_req = 1'b1; rem_pos = 8'd20;
      step();
      loc_req = 1'b0; rem_req = 1'b0;
      step();
      chk("cont_loc_load", 32'(pos_load), 1);
      chk("cont_loc_target", 32'(pos_target), 80);
      chk("cont_loc_grant", 32'(grant), 2);
      step();
      chk("cont_ignore_ready_a", 32'(done), 0);
      step();
      chk("cont_ignore_ready_b", 32'(done), 0);
      step();
      chk("cont_loc_done", 32'(done), 1);
      tick_step();
      tick_step();
      chk("cont_settle_idle_grant", 32'(grant), 0);
      step();
      chk("cont_rem_load", 32'(pos_load), 1);
      chk("cont_rem_target", 32'(pos_target), 160);
      chk("cont_rem_grant", 32'(grant), 3);
      step(); step(); step();
      chk("cont_rem_done", 32'(done), 1);
      tick_step();
      tick_step();
      chk("cont_rem_idle_busy", 32'(busy), 0);

      // Safety preemption during a remote move, with a locked-out loc request
      rem_req = 1'b1; rem_pos = 8'h64;
      step();
      rem_req = 1'b0;
      step();
      chk("pre_rem_target", 32'(pos_target), 800);
      pos_ready = 1'b0;
      step(); step();
      safe_req = 1'b1; safe_pos = 8'h00; loc_req = 1'b1; loc_pos = 8'h33;
      step();
      loc_req = 1'b0;
      chk("pre_safe_load", 32'(pos_load), 1);
      chk("pre_safe_target", 32'(pos_target), 0);
      chk("pre_safe_grant", 32'(grant), 1);
      step();
      step();
      pos_ready = 1'b1;
      step();
      chk("pre_safe_done", 32'(done), 1);
      chk("pre_safe_done_grant", 32'(grant), 1);
      tick_step();
      tick_step();
      chk("pre_safe_idle_busy", 32'(busy), 0);
      count_loads(4);
      chk("lockout_safe_held_loads", 32'(n_load), 0);
      safe_req = 1'b0;
      count_loads(5);
      chk("lockout_loc_discarded", 32'(n_load), 0);

      // Watchdog: 16 ticks with ready low after load
      rem_req = 1'b1; rem_pos = 8'h05;
      step();
      rem_req = 1'b0;
      step();
      chk("wd_load", 32'(pos_load), 1);
      chk("wd_target", 32'(pos_target), 40);
      pos_ready = 1'b0;
      step();
      for (int i = 0; i < 15; i++) tick_step();
      chk("wd_15_ticks_fault", 32'(fault), 0);
      chk("wd_15_ticks_busy", 32'(busy), 1);
      tick_step();
      chk("wd_16_ticks_fault", 32'(fault), 1);
      chk("wd_fault_grant", 32'(grant), 0);
      chk("wd_fault_busy", 32'(busy), 0);
      pos_ready = 1'b1;
      rem_req = 1'b1; rem_pos = 8'h20;
      step();
      rem_req = 1'b0;
      count_loads(6);
      chk("fault_no_load", 32'(n_load), 0);
      chk("fault_no_home", 32'(n_home), 0);
      chk("fault_sticky", 32'(fault), 1);

      // Reset after fault
      rst_n = 1'b0;
      step();
      chk("rst_fault_clear", 32'(fault), 0);
      chk("rst_fault_busy", 32'(busy), 0);
      chk("rst_fault_target", 32'(pos_target), 0);
      step();
      rst_n = 1'b1;
      step();
      chk("recover_home", 32'(pos_home), 1);
      chk("recover_fault", 32'(fault), 0);
      wait_idle("recover_idle");

      // Reset mid-move with a loc request pending
      rem_req = 1'b1; rem_pos = 8'h10;
      step();
      rem_req = 1'b0;
      step();
      chk("mid_target", 32'(pos_target), 128);
      pos_ready = 1'b0;
      step();
      loc_req = 1'b1; loc_pos = 8'h07;
      step();
      loc_req = 1'b0;
      rst_n = 1'b0;
      step();
      chk("mid_rst_busy", 32'(busy), 0);
      chk("mid_rst_grant", 32'(grant), 0);
      chk("mid_rst_target", 32'(pos_target), 0);
      chk("mid_rst_load", 32'(pos_load), 0);
      rst_n = 1'b1; pos_ready = 1'b1;
      step();
      chk("mid_recover_home", 32'(pos_home), 1);
      wait_idle("mid_recover_idle");
      count_loads(6);
      chk("mid_pending_cleared", 32'(n_load), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
